// File: rtl/stop_it_ctrl.sv
// rtl/stop_it_ctrl.sv - "Stop It" game sequencer: paces shifts, judges stop, tracks level.
// Optional STOP_IT_AUTOSTART_EN: after the win animation go straight to LOAD instead of IDLE.
module stop_it_ctrl #(
    parameter int unsigned DIV_INIT      = 8,
    parameter int unsigned DIV_MIN       = 2,
    parameter int unsigned NUM_LEDS      = 16,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       load_o,
    output logic       shift_o,
    output logic       off_o,
    output logic [3:0] level_o,
    output logic       win_o,
    output logic       lose_o,
    output logic       busy_o
);

    localparam int unsigned DIV_MAX = (DIV_INIT > DIV_MIN) ? DIV_INIT : DIV_MIN;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
    localparam int unsigned SH_W    = $clog2(NUM_LEDS + 1);
    localparam int unsigned BL_W    = $clog2(BLINK_TOGGLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        level_q, level_d;
    logic [SH_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              off_q, off_d;
    logic              bar_full;

    // Shift period shrinks by one tick per level, clamped at DIV_MIN without wrapping.
    function automatic logic [DIV_W-1:0] period(input logic [3:0] lvl);
        int unsigned p;
        if (DIV_INIT > 32'(lvl) + DIV_MIN) begin
            p = DIV_INIT - 32'(lvl);
        end else begin
            p = DIV_MIN;
        end
        return DIV_W'(p);
    endfunction

    assign bar_full = (shift_cnt_q == SH_W'(NUM_LEDS));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            shift_cnt_q <= '0;
            div_cnt_q   <= '0;
            blink_cnt_q <= '0;
            off_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            shift_cnt_q <= shift_cnt_d;
            div_cnt_q   <= div_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            off_q       <= off_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        shift_cnt_d = shift_cnt_q;
        div_cnt_d   = div_cnt_q;
        blink_cnt_d = blink_cnt_q;
        off_d       = off_q;
        shift_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                shift_cnt_d = '0;
                div_cnt_d   = period(level_q);
                state_d     = S_RUN;
            end

            S_RUN: begin
                // A stop press always wins priority over a tick in the same cycle.
                if (stop_i) begin
                    if (bar_full) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_LOSE;
                        off_d   = 1'b1;
                    end
                end else if (tick_i) begin
                    if (div_cnt_q > DIV_W'(1)) begin
                        div_cnt_d = div_cnt_q - DIV_W'(1);
                    end else if (!bar_full) begin
                        shift_o     = 1'b1;
                        shift_cnt_d = shift_cnt_q + SH_W'(1);
                        div_cnt_d   = period(level_q);
                    end else begin
                        state_d = S_LOSE;
                        off_d   = 1'b1;
                    end
                end
            end

            S_WIN: begin
                if (tick_i) begin
                    off_d = ~off_q;
                    if (blink_cnt_q == BL_W'(BLINK_TOGGLES - 1)) begin
                        off_d       = 1'b0;
                        blink_cnt_d = '0;
                        level_d     = (level_q == 4'd15) ? level_q : level_q + 4'd1;
`ifdef STOP_IT_AUTOSTART_EN
                        state_d     = S_LOAD;
`else
                        state_d     = S_IDLE;
`endif
                    end else begin
                        blink_cnt_d = blink_cnt_q + BL_W'(1);
                    end
                end
            end

            S_LOSE: begin
                if (start_i) begin
                    level_d = '0;
                    off_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_o  = (state_q == S_LOAD);
    assign win_o   = (state_q == S_WIN);
    assign lose_o  = (state_q == S_LOSE);
    assign busy_o  = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_WIN);
    assign off_o   = off_q;
    assign level_o = level_q;

endmodule
